// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Function : 16-bit CPU instruction fetch.
//            Owns the PC, drives the imem request/ready handshake and owns
//            the IF/ID register.
// Config   : define FETCH_HALT_DETECT_EN to enable HLT detection (HALT state)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        flush_in,
   input  logic [15:0] branch_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic [15:0] pc_out,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc_plus2,
   output logic        ifid_valid,
   output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
   typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1} state_t;
`endif

   state_t      state;
   logic [15:0] pc;
   logic [15:0] redirect;
   logic [15:0] target;
   logic [15:0] pc_plus2;

   assign target    = branch_pc & 16'hFFFE;
   assign pc_plus2  = pc + 16'd2;
   assign pc_out    = pc;
   assign imem_addr = pc;

`ifdef FETCH_HALT_DETECT_EN
   assign imem_req = (state != HALT);
   assign halted   = (state == HALT);
`else
   assign imem_req = 1'b1;
   assign halted   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FETCH;
         pc            <= 16'h0000;
         redirect      <= 16'h0000;
         ifid_instr    <= 16'h0000;
         ifid_pc_plus2 <= 16'h0000;
         ifid_valid    <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (flush_in) begin
                  ifid_instr    <= 16'h0000;
                  ifid_pc_plus2 <= 16'h0000;
                  ifid_valid    <= 1'b0;
                  if (imem_rdy) begin
                     pc <= target;
                  end else begin
                     // memory still owes a response for pc; park the target
                     redirect <= target;
                     state    <= DRAIN;
                  end
               end else if (imem_rdy) begin
                  if (!stall_in) begin
                     ifid_instr    <= imem_data;
                     ifid_pc_plus2 <= pc_plus2;
                     ifid_valid    <= 1'b1;
`ifdef FETCH_HALT_DETECT_EN
                     if (imem_data[15:12] == 4'hF)
                        state <= HALT;
                     else
                        pc <= pc_plus2;
`else
                     pc <= pc_plus2;
`endif
                  end
               end else if (!stall_in) begin
                  ifid_instr    <= 16'h0000;
                  ifid_pc_plus2 <= 16'h0000;
                  ifid_valid    <= 1'b0;
               end
            end

            DRAIN: begin
               if (flush_in)
                  redirect <= target;
               if (flush_in || !stall_in) begin
                  ifid_instr    <= 16'h0000;
                  ifid_pc_plus2 <= 16'h0000;
                  ifid_valid    <= 1'b0;
               end
               if (imem_rdy) begin
                  pc    <= flush_in ? target : redirect;
                  state <= FETCH;
               end
            end

`ifdef FETCH_HALT_DETECT_EN
            HALT: begin
               if (flush_in || !stall_in) begin
                  ifid_instr    <= 16'h0000;
                  ifid_pc_plus2 <= 16'h0000;
                  ifid_valid    <= 1'b0;
               end
               if (flush_in) begin
                  pc    <= target;
                  state <= FETCH;
               end
            end
`endif

            default: state <= FETCH;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Function : directed self-checking bench for fetch_stage
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic        flush_in;
   logic [15:0] branch_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic [15:0] pc_out;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_plus2;
   logic        ifid_valid;
   logic        halted;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall_in      (stall_in),
      .flush_in      (flush_in),
      .branch_pc     (branch_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdy      (imem_rdy),
      .imem_data     (imem_data),
      .pc_out        (pc_out),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .ifid_valid    (ifid_valid),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // word = address, except HLT at 0x0030 and the 0xF page masked to avoid HLT
   always_comb begin
      if (imem_addr == 16'h0030)
         imem_data = 16'hF000;
      else if (imem_addr[15:12] == 4'hF)
         imem_data = imem_addr & 16'h0FFF;
      else
         imem_data = imem_addr;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; branch_pc = 16'h0000; imem_rdy = 1'b1;
      repeat (2) step();
      check("rst_pc", pc_out, 16'h0000);
      check("rst_instr", ifid_instr, 16'h0000);
      check("rst_pp2", ifid_pc_plus2, 16'h0000);
      check("rst_valid", {15'd0, ifid_valid}, 16'd0);
      check("rst_halted", {15'd0, halted}, 16'd0);
      check("rst_req", {15'd0, imem_req}, 16'd1);
      rst = 1'b0;

      // zero-wait streaming
      for (int i = 0; i < 3; i++) begin
         step();
         check("stream_instr", ifid_instr, 16'(2 * i));
         check("stream_valid", {15'd0, ifid_valid}, 16'd1);
      end
      step();
      check("stream_pc", pc_out, 16'h0008);
      check("stream_pp2", ifid_pc_plus2, 16'h0008);

      // memory wait states at 0x0010
      repeat (4) step();
      check("pre_wait_pc", pc_out, 16'h0010);
      imem_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_addr", imem_addr, 16'h0010);
         check("wait_valid", {15'd0, ifid_valid}, 16'd0);
      end
      imem_rdy = 1'b1;
      step();
      check("wait_instr", ifid_instr, 16'h0010);
      check("wait_pp2", ifid_pc_plus2, 16'h0012);
      check("wait_valid1", {15'd0, ifid_valid}, 16'd1);

      // stall two cycles at 0x0020
      repeat (7) step();
      check("pre_stall_pc", pc_out, 16'h0020);
      stall_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_pc", pc_out, 16'h0020);
         check("stall_instr", ifid_instr, 16'h001E);
      end
      stall_in = 1'b0;
      step();
      check("unstall_instr", ifid_instr, 16'h0020);
      check("unstall_pc", pc_out, 16'h0022);

      // flush while memory busy -> DRAIN
      imem_rdy = 1'b0; flush_in = 1'b1; branch_pc = 16'h0100;
      step();
      check("drain_addr", imem_addr, 16'h0022);
      check("drain_valid", {15'd0, ifid_valid}, 16'd0);
      flush_in = 1'b0;
      step();
      check("drain_addr2", imem_addr, 16'h0022);
      flush_in = 1'b1; stall_in = 1'b1;
      step();
      check("drain_flush_stall", {15'd0, ifid_valid}, 16'd0);
      flush_in = 1'b0; stall_in = 1'b0; imem_rdy = 1'b1;
      step();
      check("redirect_addr", imem_addr, 16'h0100);
      check("redirect_drop", {15'd0, ifid_valid}, 16'd0);
      step();
      check("redirect_instr", ifid_instr, 16'h0100);
      check("redirect_pc", pc_out, 16'h0102);

      // flush + stall in FETCH, odd target forced even
      flush_in = 1'b1; stall_in = 1'b1; branch_pc = 16'h002F;
      step();
      check("flush_stall_pc", pc_out, 16'h002E);
      check("flush_stall_bub", ifid_instr, 16'h0000);
      check("flush_stall_val", {15'd0, ifid_valid}, 16'd0);
      flush_in = 1'b0; stall_in = 1'b0;
      step();
      check("pre_hlt_instr", ifid_instr, 16'h002E);

      // HLT at 0x0030
      step();
      check("hlt_instr", ifid_instr, 16'hF000);
      check("hlt_pp2", ifid_pc_plus2, 16'h0032);
`ifdef FETCH_HALT_DETECT_EN
      check("hlt_halted", {15'd0, halted}, 16'd1);
      check("hlt_req", {15'd0, imem_req}, 16'd0);
      check("hlt_pc", pc_out, 16'h0030);
      step();
      check("hlt_hold_pc", pc_out, 16'h0030);
      check("hlt_bubble", {15'd0, ifid_valid}, 16'd0);
`else
      check("hlt_halted", {15'd0, halted}, 16'd0);
      check("hlt_req", {15'd0, imem_req}, 16'd1);
      check("hlt_pc", pc_out, 16'h0032);
      step();
      check("hlt_next_instr", ifid_instr, 16'h0032);
`endif
      flush_in = 1'b1; branch_pc = 16'h0040;
      step();
      check("unhalt_pc", pc_out, 16'h0040);
      check("unhalt_halted", {15'd0, halted}, 16'd0);
      check("unhalt_req", {15'd0, imem_req}, 16'd1);

      // PC wrap at 0xFFFE
      branch_pc = 16'hFFFC;
      step();
      flush_in = 1'b0;
      step();
      check("wrap_pre", ifid_instr, 16'h0FFC);
      step();
      check("wrap_pp2", ifid_pc_plus2, 16'h0000);
      check("wrap_instr", ifid_instr, 16'h0FFE);
      check("wrap_addr", imem_addr, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
